// File: rtl/arith_serial_harness_if.sv
`default_nettype none
// ============================================================================
// Module   : arith_serial_harness_if
// Brief    : Operand load, start/mode control and readout bus for
//            arith_serial_harness.
// Revision : 1.0 - initial release
// ============================================================================
interface arith_serial_harness_if #(
    parameter int LOG2_BYTES_IN = 3
);
    logic [7:0]               data_in;
    logic                     we;
    logic [LOG2_BYTES_IN-1:0] sel_in;
    logic                     start;
    logic [1:0]               mode;
    logic [LOG2_BYTES_IN-1:0] sel_out;
    logic [7:0]               data_out;
    logic                     busy;
    logic                     done;

    modport master (
        output data_in, we, sel_in, start, mode, sel_out,
        input  data_out, busy, done
    );

    modport slave (
        input  data_in, we, sel_in, start, mode, sel_out,
        output data_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/arith_serial_harness.sv
`default_nettype none
// ============================================================================
// Module   : arith_serial_harness
// Brief    : Digit-serial add/sub/nand/xor over two W-bit operands held in a
//            byte-addressable buffer, with byte readout of result and status.
// Revision : 1.0 - initial release
// ============================================================================
module arith_serial_harness #(
    parameter int LOG2_BYTES_IN = 3,
    parameter int LOG2_DIGIT    = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    arith_serial_harness_if.slave  bus
);
    localparam int c_BYTES = 2 ** LOG2_BYTES_IN;
    localparam int c_W     = 4 * c_BYTES;
    localparam int c_D     = 2 ** LOG2_DIGIT;
    localparam int c_N     = c_W / c_D;
    localparam int c_CW    = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_HALF  = c_BYTES / 2;

    localparam logic [c_CW-1:0]          c_LAST     = c_CW'(c_N - 1);
    localparam logic [c_CW-1:0]          c_CNT_ONE  = c_CW'(1);
    localparam logic [LOG2_BYTES_IN-1:0] c_STAT_IDX = LOG2_BYTES_IN'(c_HALF);

    localparam logic [1:0] c_MODE_ADD  = 2'b00;
    localparam logic [1:0] c_MODE_SUB  = 2'b01;
    localparam logic [1:0] c_MODE_NAND = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [c_BYTES-1:0][7:0]  ops_q,   ops_d;
    logic [c_W-1:0]           xs_q,    xs_d;
    logic [c_W-1:0]           ys_q,    ys_d;
    logic [c_W-1:0]           res_q,   res_d;
    logic                     carry_q, carry_d;
    logic                     cout_q,  cout_d;
    logic                     zero_q,  zero_d;
    logic [1:0]               mode_q,  mode_d;
    logic [c_CW-1:0]          cnt_q,   cnt_d;

    logic [2*c_W-1:0] w_ops_flat;
    logic [c_W-1:0]   w_x;
    logic [c_W-1:0]   w_y;
    logic [c_D-1:0]   w_dx;
    logic [c_D-1:0]   w_dy;
    logic [c_D:0]     w_sum;
    logic [c_D-1:0]   w_digit;
    logic             w_arith;
    logic             w_carry_next;
    logic [c_W-1:0]   w_res_next;
    logic             w_busy;
    logic [7:0]       w_data_out;

    // x occupies the low half of the byte buffer, y the high half.
    assign w_ops_flat = ops_q;
    assign w_x        = w_ops_flat[c_W-1:0];
    assign w_y        = w_ops_flat[2*c_W-1:c_W];

    assign w_arith = (mode_q == c_MODE_ADD) || (mode_q == c_MODE_SUB);
    assign w_dx    = xs_q[c_D-1:0];
    assign w_dy    = (mode_q == c_MODE_SUB) ? ~ys_q[c_D-1:0] : ys_q[c_D-1:0];
    assign w_sum   = {1'b0, w_dx} + {1'b0, w_dy} + {{c_D{1'b0}}, carry_q};

    always_comb begin
        w_digit = w_sum[c_D-1:0];
        if (mode_q == c_MODE_NAND) begin
            w_digit = ~(xs_q[c_D-1:0] & ys_q[c_D-1:0]);
        end else if (!w_arith) begin
            w_digit = xs_q[c_D-1:0] ^ ys_q[c_D-1:0];
        end
    end

    assign w_carry_next = w_arith ? w_sum[c_D] : carry_q;

    // New digit enters at the MSB end; after N digits the LSB digit has
    // travelled down to bit 0.
    assign w_res_next = (res_q >> c_D) | (c_W'(w_digit) << (c_W - c_D));

    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    xs_d    = w_x;
                    ys_d    = w_y;
                    res_d   = '0;
                    carry_d = (bus.mode == c_MODE_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (bus.we) begin
                    ops_d[bus.sel_in] = bus.data_in;
                end
            end
            ST_RUN: begin
                xs_d    = xs_q >> c_D;
                ys_d    = ys_q >> c_D;
                res_d   = w_res_next;
                carry_d = w_carry_next;
                cnt_d   = cnt_q + c_CNT_ONE;
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    cout_d  = w_arith ? w_carry_next : 1'b0;
                    zero_d  = (w_res_next == '0);
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ops_q   <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_busy = (state_q == ST_RUN);

    always_comb begin
        w_data_out = 8'h00;
        if (bus.sel_out < c_STAT_IDX) begin
            w_data_out = 8'(res_q >> {bus.sel_out, 3'b000});
        end else if (bus.sel_out == c_STAT_IDX) begin
            w_data_out = {5'b00000, w_busy, zero_q, cout_q};
        end
    end

    assign bus.data_out = w_data_out;
    assign bus.busy     = w_busy;
    assign bus.done     = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_arith_serial_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_serial_harness
// Brief    : Self-checking bench driving three digit widths (D=4, 1, 32) in
//            lockstep against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_serial_harness;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] t_data_in;
    logic       t_we;
    logic [2:0] t_sel_in;
    logic       t_start;
    logic [1:0] t_mode;
    logic [2:0] t_sel_out;

    int checks   = 0;
    int failures = 0;
    int busy_cnt [3];
    logic [31:0] res_rd  [3];
    logic [7:0]  stat_rd [3];

    always #5 clk = ~clk;

    arith_serial_harness_if #(.LOG2_BYTES_IN(3)) if0 ();
    arith_serial_harness_if #(.LOG2_BYTES_IN(3)) if1 ();
    arith_serial_harness_if #(.LOG2_BYTES_IN(3)) if2 ();

    assign if0.data_in = t_data_in;  assign if1.data_in = t_data_in;  assign if2.data_in = t_data_in;
    assign if0.we      = t_we;       assign if1.we      = t_we;       assign if2.we      = t_we;
    assign if0.sel_in  = t_sel_in;   assign if1.sel_in  = t_sel_in;   assign if2.sel_in  = t_sel_in;
    assign if0.start   = t_start;    assign if1.start   = t_start;    assign if2.start   = t_start;
    assign if0.mode    = t_mode;     assign if1.mode    = t_mode;     assign if2.mode    = t_mode;
    assign if0.sel_out = t_sel_out;  assign if1.sel_out = t_sel_out;  assign if2.sel_out = t_sel_out;

    arith_serial_harness #(.LOG2_BYTES_IN(3), .LOG2_DIGIT(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    arith_serial_harness #(.LOG2_BYTES_IN(3), .LOG2_DIGIT(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    arith_serial_harness #(.LOG2_BYTES_IN(3), .LOG2_DIGIT(5)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Expected busy length W/D for each instance.
    function automatic int ncyc(int d);
        case (d)
            0:       return 8;
            1:       return 32;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] dout(int d);
        case (d)
            0:       return if0.data_out;
            1:       return if1.data_out;
            default: return if2.data_out;
        endcase
    endfunction

    function automatic logic busy_of(int d);
        case (d)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic done_of(int d);
        case (d)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    // Reference: whole-word arithmetic, returns {cout, result}.
    function automatic logic [32:0] ref_op(logic [31:0] x, logic [31:0] y, logic [1:0] m);
        case (m)
            2'd0:    return {1'b0, x} + {1'b0, y};
            2'd1:    return {1'b0, x} + {1'b0, ~y} + 33'd1;
            2'd2:    return {1'b0, ~(x & y)};
            default: return {1'b0, x ^ y};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [31:0] x, logic [31:0] y);
        t_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t_sel_in  = 3'(i);
            t_data_in = (i < 4) ? x[i*8 +: 8] : y[(i-4)*8 +: 8];
            tick();
        end
        t_we = 1'b0;
    endtask

    task automatic start_op(logic [1:0] m);
        t_start = 1'b1;
        t_mode  = m;
        tick();
        t_start = 1'b0;
    endtask

    task automatic wait_all(string tag);
        logic [2:0] dn;
        for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
        dn = 3'b000;
        for (int it = 0; it < 200; it++) begin
            for (int d = 0; d < 3; d++) begin
                if (busy_of(d)) busy_cnt[d]++;
                dn[d] = done_of(d);
            end
            if (dn == 3'b111) break;
            tick();
        end
        chk({tag, " done_all"}, 32'(dn), 32'h7);
    endtask

    task automatic read_all();
        for (int b = 0; b < 4; b++) begin
            t_sel_out = 3'(b);
            #1;
            for (int d = 0; d < 3; d++) res_rd[d][b*8 +: 8] = dout(d);
        end
        t_sel_out = 3'd4;
        #1;
        for (int d = 0; d < 3; d++) stat_rd[d] = dout(d);
    endtask

    task automatic check_vs_model(string tag, logic [31:0] x, logic [31:0] y, logic [1:0] m);
        logic [32:0] r;
        r = ref_op(x, y, m);
        read_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d result", tag, d), res_rd[d], r[31:0]);
            chk($sformatf("%s d%0d status", tag, d), 32'(stat_rd[d]),
                32'({5'b0, 1'b0, (r[31:0] == 32'h0), r[32]}));
            chk($sformatf("%s d%0d busylen", tag, d), 32'(busy_cnt[d]), 32'(ncyc(d)));
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  m;
        logic [31:0] er;
        logic [7:0]  es;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [31:0] rx, ry;
        logic [1:0]  rm;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 32'h0000_0000, 8'h03};
        tbl[1] = '{32'h0000_0005, 32'h0000_0007, 2'd1, 32'hFFFF_FFFE, 8'h00};
        tbl[2] = '{32'h0000_0007, 32'h0000_0005, 2'd1, 32'h0000_0002, 8'h01};
        tbl[3] = '{32'hF0F0_00FF, 32'hFF00_0F0F, 2'd2, 32'h0FFF_FFF0, 8'h00};
        tbl[4] = '{32'hF0F0_00FF, 32'hFF00_0F0F, 2'd3, 32'h0FF0_0FF0, 8'h00};
        tbl[5] = '{32'h1234_5678, 32'h1234_5678, 2'd3, 32'h0000_0000, 8'h02};
        tbl[6] = '{32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000, 8'h03};

        rst = 1'b1; t_data_in = 8'h00; t_we = 1'b0; t_sel_in = 3'd0;
        t_start = 1'b0; t_mode = 2'd0; t_sel_out = 3'd0;
        tick();
        tick();
        rst = 1'b0;

        for (int s = 0; s < 8; s++) begin
            t_sel_out = 3'(s);
            #1;
            chk($sformatf("reset dout sel%0d", s), 32'(dout(0)), 32'h0);
        end
        chk("reset busy", 32'(if0.busy), 32'h0);
        chk("reset done", 32'(if0.done), 32'h0);

        for (int i = 0; i < 7; i++) begin
            load(tbl[i].x, tbl[i].y);
            start_op(tbl[i].m);
            wait_all($sformatf("vec%0d", i));
            read_all();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d d%0d result", i, d), res_rd[d], tbl[i].er);
                chk($sformatf("vec%0d d%0d status", i, d), 32'(stat_rd[d]), 32'(tbl[i].es));
                chk($sformatf("vec%0d d%0d busylen", i, d), 32'(busy_cnt[d]), 32'(ncyc(d)));
            end
        end

        // Collisions: write alongside start is dropped; start/we during RUN ignored.
        load(32'h1234_5678, 32'h1111_1111);
        t_start = 1'b1; t_mode = 2'd0; t_we = 1'b1; t_sel_in = 3'd0; t_data_in = 8'hAA;
        tick();
        t_start = 1'b0; t_we = 1'b0;
        tick();
        t_start = 1'b1; t_mode = 2'd3; t_we = 1'b1; t_sel_in = 3'd4; t_data_in = 8'h55;
        tick();
        t_start = 1'b0; t_we = 1'b0;
        wait_all("collide");
        read_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("collide d%0d result", d), res_rd[d], 32'h2345_6789);
            chk($sformatf("collide d%0d status", d), 32'(stat_rd[d]), 32'h0);
        end
        for (int s = 5; s < 8; s++) begin
            t_sel_out = 3'(s);
            #1;
            chk($sformatf("high sel%0d", s), 32'(dout(0)), 32'h0);
        end
        start_op(2'd0);
        wait_all("restart");
        check_vs_model("restart", 32'h1234_5678, 32'h1111_1111, 2'd0);

        // Reset during RUN cycle 3 aborts without DONE.
        load(32'hAAAA_5555, 32'h0000_1234);
        start_op(2'd0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst d%0d busy", d), 32'(busy_of(d)), 32'h0);
            chk($sformatf("midrst d%0d done", d), 32'(done_of(d)), 32'h0);
        end
        for (int s = 0; s < 8; s++) begin
            t_sel_out = 3'(s);
            #1;
            chk($sformatf("midrst dout sel%0d", s), 32'(dout(0)), 32'h0);
        end
        tick();
        chk("midrst still idle", 32'(if0.done), 32'h0);
        load(32'hAAAA_5555, 32'h0000_1234);
        start_op(2'd1);
        wait_all("postrst");
        check_vs_model("postrst", 32'hAAAA_5555, 32'h0000_1234, 2'd1);

        for (int n = 0; n < 20; n++) begin
            rx = $urandom;
            ry = $urandom;
            rm = 2'($urandom_range(0, 3));
            load(rx, ry);
            start_op(rm);
            wait_all($sformatf("rand%0d", n));
            check_vs_model($sformatf("rand%0d", n), rx, ry, rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/arith_serial_harness.md
ARITH_SERIAL_HARNESS -- requirements
Module: arith_serial_harness

Interface
REQ-001 SHALL have parameter LOG2_BYTES_IN, default 3: operand buffer is BYTES_IN = 2**LOG2_BYTES_IN bytes, split into x (low half) and y (high half), each W = 4*BYTES_IN bits.
REQ-002 SHALL have parameter LOG2_DIGIT, default 2: digit width D = 2**LOG2_DIGIT bits per cycle; legal range 0 <= LOG2_DIGIT <= LOG2_BYTES_IN+2; N = W/D run cycles.
REQ-003 SHALL have ports:
 clk  in  1  clock, all state on rising edge
 rst  in  1  reset, synchronous, active-high
 data_in  in  8  operand byte to write
 we  in  1  write strobe for data_in
 sel_in  in  LOG2_BYTES_IN  operand byte index
 start  in  1  begin operation
 mode  in  2  operation: 00 add, 01 sub, 10 nand, 11 xor
 sel_out  in  LOG2_BYTES_IN  readout byte index
 data_out  out  8  selected result/status byte
 busy  out  1  high while computing
 done  out  1  high while result is valid

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-005 In IDLE or DONE, we=1 and start=0 SHALL write data_in into operand byte sel_in at the clock edge; other bytes unchanged.
REQ-006 we SHALL be ignored in RUN and in any cycle where start is accepted (start has priority).
REQ-007 start=1 in IDLE or DONE SHALL latch mode, copy x and y into working shift registers, clear the result register, set carry to 1 for sub else 0, and enter RUN; start in RUN SHALL be ignored.
REQ-008 Each RUN cycle SHALL process the lowest D bits of the working operands, LSB digit first: add = x+y+c, sub = x+~y+c, nand = ~(x&y), xor = x^y; carry updated only for add/sub.
REQ-009 Result digits SHALL be shifted into the result register from the MSB end so that after N cycles result[W-1:0] holds the full W-bit answer, modulo 2**W.
REQ-010 A RUN cycle counter SHALL run 0..N-1; on the edge completing digit N-1 the FSM SHALL enter DONE; start accepted at edge k gives done=1 after edge k+N+... precisely: busy high for exactly N cycles, done rises on the edge after the last digit.
REQ-011 On entering DONE SHALL capture status: cout = final carry (add: carry-out; sub: 1 = no borrow; nand/xor: 0), zero = (result==0).
REQ-012 DONE SHALL persist, result and status held, until rst or an accepted start; operand writes in DONE SHALL NOT alter result.
REQ-013 data_out SHALL be combinational from registers: sel_out < BYTES_IN/2 -> result byte sel_out; sel_out == BYTES_IN/2 -> {5'b0, busy, zero, cout}; larger indices -> 8'h00.
REQ-014 Result bytes read during RUN SHALL show the partially shifted result register unchanged by any masking.
REQ-015 Operand registers SHALL keep their values across operations (re-start with same operands repeats result).

Reset
REQ-016 rst=1 at a clock edge SHALL force IDLE, clear operands, result, carry, counter, cout, zero to 0; busy=0, done=0, data_out=8'h00 for every sel_out from the following cycle.
REQ-017 rst SHALL override start and we in the same cycle and SHALL abort a RUN in progress with no DONE entry.

Verification (defaults: W=32, D=4, N=8)
REQ-018 Add wrap: x=32'hFFFFFFFF, y=32'h00000001, mode=00, start -> busy 8 cycles, then result=32'h00000000, cout=1, zero=1, status byte 8'h03.
REQ-019 Sub borrow: x=5, y=7, mode=01 -> result=32'hFFFFFFFE, cout=0, zero=0; then x=7,y=5 -> result=2, cout=1.
REQ-020 Logic modes: x=32'hF0F0_00FF, y=32'hFF00_0F0F; nand -> 32'h0FFF_FFF0, xor -> 32'h0FF0_0FF0, cout=0 both.
REQ-021 Collisions: start and we together in IDLE -> write dropped; start/we during RUN ignored, result unchanged from single-operation reference; sel_out=5..7 reads 8'h00.
REQ-022 Reset mid-run: rst asserted at RUN cycle 3 -> next cycle busy=0, done=0, all readouts 8'h00; fresh load+start completes normally.
REQ-023 Parameter sweep: LOG2_DIGIT in {0,2,5} with random operands/modes compared against a reference model, busy length = W/D exactly.
